backend_port_arbiter: RTL

BACKEND_PORT_ARBITER -- requirements
Module: backend_port_arbiter

---
 rtl/backend_port_arbiter.sv | 237 +++++++++++++++++++++++
 1 files changed

// File: rtl/backend_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : backend_port_arbiter
// Purpose  : Serialises NPORTS requester ports onto one memory channel with a
//            single transaction outstanding. Ports are served in arrival
//            order through a queue of port indices that holds each port at
//            most once.
// Ports    : clock, reset          - rising-edge clock, sync active-high reset
//            req_*                 - per-port request channel (valid/ready)
//            rsp_*                 - per-port response valid/ready, with
//                                    shared id/data/resp
//            mem_req_* / mem_rsp_* - single memory request/response channel
//            err_id                - sticky flag: response ID != request ID
// Revision : 1.0 - initial release
// ============================================================================
module backend_port_arbiter #(
    parameter int NPORTS   = 9,
    parameter int IDBITS   = 4,
    parameter int ADDRBITS = 32,
    parameter int DATABITS = 512
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic [NPORTS-1:0]            req_valid,
    output logic [NPORTS-1:0]            req_ready,
    input  logic [NPORTS*IDBITS-1:0]     req_id,
    input  logic [NPORTS*ADDRBITS-1:0]   req_addr,
    input  logic [NPORTS*DATABITS-1:0]   req_data,
    input  logic [NPORTS-1:0]            req_rw,
    output logic [NPORTS-1:0]            rsp_valid,
    input  logic [NPORTS-1:0]            rsp_ready,
    output logic [IDBITS-1:0]            rsp_id,
    output logic [DATABITS-1:0]          rsp_data,
    output logic [1:0]                   rsp_resp,
    output logic                         mem_req_valid,
    input  logic                         mem_req_ready,
    output logic [IDBITS-1:0]            mem_req_id,
    output logic [ADDRBITS-1:0]          mem_req_addr,
    output logic [DATABITS-1:0]          mem_req_data,
    output logic                         mem_req_rw,
    input  logic                         mem_rsp_valid,
    output logic                         mem_rsp_ready,
    input  logic [IDBITS-1:0]            mem_rsp_id,
    input  logic [DATABITS-1:0]          mem_rsp_data,
    input  logic [1:0]                   mem_rsp_resp,
    output logic                         err_id
);
    localparam int PW = (NPORTS > 1) ? $clog2(NPORTS) : 1;
    localparam int CW = $clog2(NPORTS + 1);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_ISSUE    = 2'd1,
        ST_WAIT_RSP = 2'd2,
        ST_DELIVER  = 2'd3
    } state_t;

    state_t              r_state;
    state_t              w_state_next;
    logic [PW-1:0]       r_queue      [NPORTS];
    logic [PW-1:0]       w_queue_next [NPORTS];
    logic [CW-1:0]       r_count;
    logic [CW-1:0]       w_count_next;
    logic [PW-1:0]       w_wr_idx;
    logic [NPORTS-1:0]   r_queued;
    logic [NPORTS-1:0]   w_queued_next;
    logic [NPORTS-1:0]   r_inflight;

    logic [PW-1:0]       r_port;
    logic [IDBITS-1:0]   r_id;
    logic [ADDRBITS-1:0] r_addr;
    logic [DATABITS-1:0] r_data;
    logic                r_rw;
    logic [DATABITS-1:0] r_rsp_data;
    logic [1:0]          r_rsp_resp;
    logic                r_err;

    logic [PW-1:0]       w_head;
    logic [NPORTS-1:0]   w_head_onehot;
    logic [IDBITS-1:0]   w_sel_id;
    logic [ADDRBITS-1:0] w_sel_addr;
    logic [DATABITS-1:0] w_sel_data;
    logic                w_sel_rw;
    logic                w_pop;
    logic                w_grant;
    logic                w_rsp_hs;
    logic                w_mem_rsp_hs;

    assign w_head = r_queue[0];

    // Decode the queue head and select its request fields.
    always_comb begin
        w_head_onehot = '0;
        w_sel_id      = '0;
        w_sel_addr    = '0;
        w_sel_data    = '0;
        w_sel_rw      = 1'b0;
        for (int p = 0; p < NPORTS; p++) begin
            if (w_head == PW'(p)) begin
                w_head_onehot[p] = 1'b1;
                w_sel_id         = req_id[p*IDBITS +: IDBITS];
                w_sel_addr       = req_addr[p*ADDRBITS +: ADDRBITS];
                w_sel_data       = req_data[p*DATABITS +: DATABITS];
                w_sel_rw         = req_rw[p];
            end
        end
    end

    // FSM next state and channel handshakes.
    always_comb begin
        w_state_next  = r_state;
        req_ready     = '0;
        rsp_valid     = '0;
        mem_req_valid = 1'b0;
        mem_rsp_ready = 1'b0;
        w_pop         = 1'b0;
        w_grant       = 1'b0;
        w_rsp_hs      = 1'b0;
        w_mem_rsp_hs  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (r_count != '0) begin
                    // The head is always popped; it is granted only if its
                    // request is still present, otherwise it is dropped.
                    w_pop = 1'b1;
                    if (|(req_valid & w_head_onehot)) begin
                        w_grant      = 1'b1;
                        req_ready    = w_head_onehot;
                        w_state_next = ST_ISSUE;
                    end
                end
            end
            ST_ISSUE: begin
                mem_req_valid = 1'b1;
                if (mem_req_ready) begin
                    w_state_next = ST_WAIT_RSP;
                end
            end
            ST_WAIT_RSP: begin
                mem_rsp_ready = 1'b1;
                if (mem_rsp_valid) begin
                    w_mem_rsp_hs = 1'b1;
                    w_state_next = ST_DELIVER;
                end
            end
            ST_DELIVER: begin
                for (int p = 0; p < NPORTS; p++) begin
                    rsp_valid[p] = (r_port == PW'(p));
                end
                if (|(rsp_valid & rsp_ready)) begin
                    w_rsp_hs     = 1'b1;
                    w_state_next = ST_IDLE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // Arrival queue: pop first, then append newly eligible ports in ascending
    // order. A port popped this cycle is still marked queued, so it cannot
    // re-enter the queue in the same cycle.
    always_comb begin
        w_queue_next  = r_queue;
        w_count_next  = r_count;
        w_queued_next = r_queued;
        w_wr_idx      = '0;
        if (w_pop) begin
            for (int i = 0; i < NPORTS - 1; i++) begin
                w_queue_next[i] = r_queue[i+1];
            end
            w_queue_next[NPORTS-1] = '0;
            w_count_next           = r_count - CW'(1);
            w_queued_next          = r_queued & ~w_head_onehot;
        end
        for (int p = 0; p < NPORTS; p++) begin
            if (req_valid[p] && !r_queued[p] && !r_inflight[p]) begin
                w_wr_idx               = w_count_next[PW-1:0];
                w_queue_next[w_wr_idx] = PW'(p);
                w_count_next           = w_count_next + CW'(1);
                w_queued_next[p]       = 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            for (int i = 0; i < NPORTS; i++) begin
                r_queue[i] <= '0;
            end
            r_count    <= '0;
            r_queued   <= '0;
            r_inflight <= '0;
            r_port     <= '0;
            r_id       <= '0;
            r_addr     <= '0;
            r_data     <= '0;
            r_rw       <= 1'b0;
            r_rsp_data <= '0;
            r_rsp_resp <= '0;
            r_err      <= 1'b0;
        end else begin
            r_state  <= w_state_next;
            r_queue  <= w_queue_next;
            r_count  <= w_count_next;
            r_queued <= w_queued_next;
            if (w_grant) begin
                r_port     <= w_head;
                r_id       <= w_sel_id;
                r_addr     <= w_sel_addr;
                r_data     <= w_sel_data;
                r_rw       <= w_sel_rw;
                r_inflight <= r_inflight | w_head_onehot;
            end else if (w_rsp_hs) begin
                r_inflight <= r_inflight & ~rsp_valid;
            end
            if (w_mem_rsp_hs) begin
                r_rsp_data <= mem_rsp_data;
                r_rsp_resp <= mem_rsp_resp;
                if (mem_rsp_id != r_id) begin
                    r_err <= 1'b1;
                end
            end
        end
    end

    assign mem_req_id   = r_id;
    assign mem_req_addr = r_addr;
    assign mem_req_data = r_data;
    assign mem_req_rw   = r_rw;
    assign rsp_id       = r_id;
    assign rsp_data     = r_rsp_data;
    assign rsp_resp     = r_rsp_resp;
    assign err_id       = r_err;

endmodule
`default_nettype wire
